// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite exclusive-access global monitor placed between an N:1 arbiter and a shared slave.
// Optional: define EXCL_MONITOR_STATS_EN for saturating exclusive-store pass/fail counters.
module ahbl_excl_monitor #(
   parameter int N_MASTERS    = 4,
   parameter int W_ADDR       = 32,
   parameter int W_DATA       = 32,
   parameter int GRANULE_LOG2 = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_hready,
   output logic              s_hready_resp,
   output logic              s_hresp,
   input  logic [W_ADDR-1:0] s_haddr,
   input  logic              s_hwrite,
   input  logic [1:0]        s_htrans,
   input  logic [2:0]        s_hsize,
   input  logic [2:0]        s_hburst,
   input  logic [3:0]        s_hprot,
   input  logic              s_hmastlock,
   input  logic [W_DATA-1:0] s_hwdata,
   output logic [W_DATA-1:0] s_hrdata,
   input  logic              s_hexcl,
   input  logic [7:0]        s_hmaster,
   output logic              s_hexokay,
   output logic              m_hready,
   input  logic              m_hready_resp,
   input  logic              m_hresp,
   output logic [W_ADDR-1:0] m_haddr,
   output logic              m_hwrite,
   output logic [1:0]        m_htrans,
   output logic [2:0]        m_hsize,
   output logic [2:0]        m_hburst,
   output logic [3:0]        m_hprot,
   output logic              m_hmastlock,
   output logic [W_DATA-1:0] m_hwdata,
   input  logic [W_DATA-1:0] m_hrdata,
   output logic [15:0]       stat_pass,
   output logic [15:0]       stat_fail
);

   localparam int W_ID  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int W_TAG = W_ADDR - GRANULE_LOG2;

   logic             accept;
   logic             id_valid;
   logic             excl_rd;
   logic             excl_wr;
   logic             plain_wr;
   logic             excl_pass;
   logic             excl_fail;
   logic [W_TAG-1:0] tag;
   logic [W_ID-1:0]  idx;

   logic             resv_v   [N_MASTERS];
   logic [W_TAG-1:0] resv_tag [N_MASTERS];

   logic             dph_valid;
   logic             dph_excl;
   logic             dph_write;
   logic             dph_fail;
   logic [W_ID-1:0]  dph_master;

   assign accept    = s_hready && s_htrans[1];
   assign tag       = s_haddr[W_ADDR-1:GRANULE_LOG2];
   assign idx       = s_hmaster[W_ID-1:0];
   assign id_valid  = 32'(s_hmaster) < 32'(N_MASTERS);
   assign excl_rd   = accept && s_hexcl && !s_hwrite;
   assign excl_wr   = accept && s_hexcl && s_hwrite;
   assign plain_wr  = accept && !s_hexcl && s_hwrite;
   assign excl_pass = excl_wr && id_valid && resv_v[idx] && (resv_tag[idx] == tag);
   assign excl_fail = excl_wr && !excl_pass;

   // Failed stores become IDLE on the slave side; everything else passes straight through.
   assign m_hready    = s_hready;
   assign m_haddr     = s_haddr;
   assign m_hwrite    = s_hwrite;
   assign m_htrans    = excl_fail ? 2'b00 : s_htrans;
   assign m_hsize     = s_hsize;
   assign m_hburst    = s_hburst;
   assign m_hprot     = s_hprot;
   assign m_hmastlock = s_hmastlock;
   assign m_hwdata    = s_hwdata;
   assign s_hrdata    = m_hrdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dph_valid  <= 1'b0;
         dph_excl   <= 1'b0;
         dph_write  <= 1'b0;
         dph_fail   <= 1'b0;
         dph_master <= '0;
      end else if (s_hready) begin
         dph_valid  <= s_htrans[1];
         dph_excl   <= s_htrans[1] && s_hexcl && id_valid;
         dph_write  <= s_hwrite;
         dph_fail   <= excl_fail;
         dph_master <= idx;
      end
   end

   // Slave-error clear is applied first so a same-cycle address-phase set overrides it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_MASTERS; i++) begin
            resv_v[W_ID'(i)]   <= 1'b0;
            resv_tag[W_ID'(i)] <= '0;
         end
      end else begin
         if (dph_valid && dph_excl && !dph_write && !dph_fail && m_hresp)
            resv_v[dph_master] <= 1'b0;
         if (excl_rd && id_valid) begin
            resv_v[idx]   <= 1'b1;
            resv_tag[idx] <= tag;
         end else if (excl_fail && id_valid) begin
            resv_v[idx] <= 1'b0;
         end else if (excl_pass || plain_wr) begin
            for (int unsigned i = 0; i < N_MASTERS; i++)
               if (resv_tag[W_ID'(i)] == tag)
                  resv_v[W_ID'(i)] <= 1'b0;
         end
      end
   end

   always_comb begin
      s_hready_resp = 1'b1;
      s_hresp       = 1'b0;
      s_hexokay     = 1'b0;
      if (dph_valid && !dph_fail) begin
         s_hready_resp = m_hready_resp;
         s_hresp       = m_hresp;
         s_hexokay     = dph_excl && !m_hresp;
      end
   end

`ifdef EXCL_MONITOR_STATS_EN
   logic [15:0] pass_q;
   logic [15:0] fail_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_q <= '0;
         fail_q <= '0;
      end else begin
         if (excl_pass && (pass_q != '1))
            pass_q <= pass_q + 16'd1;
         if (excl_fail && (fail_q != '1))
            fail_q <= fail_q + 16'd1;
      end
   end

   assign stat_pass = pass_q;
   assign stat_fail = fail_q;
`else
   assign stat_pass = '0;
   assign stat_fail = '0;
`endif

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Scoreboard bench for ahbl_excl_monitor: directed LR/SC scenarios against a zero-wait memory slave.
module tb_ahbl_excl_monitor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_hready;
   logic        s_hready_resp;
   logic        s_hresp;
   logic [31:0] s_haddr = '0;
   logic        s_hwrite = 1'b0;
   logic [1:0]  s_htrans = 2'b00;
   logic [2:0]  s_hsize = 3'b010;
   logic [2:0]  s_hburst = 3'b000;
   logic [3:0]  s_hprot = 4'b0011;
   logic        s_hmastlock = 1'b0;
   logic [31:0] s_hwdata = '0;
   logic [31:0] s_hrdata;
   logic        s_hexcl = 1'b0;
   logic [7:0]  s_hmaster = '0;
   logic        s_hexokay;
   logic        m_hready;
   logic        m_hready_resp;
   logic        m_hresp;
   logic [31:0] m_haddr;
   logic        m_hwrite;
   logic [1:0]  m_htrans;
   logic [2:0]  m_hsize;
   logic [2:0]  m_hburst;
   logic [3:0]  m_hprot;
   logic        m_hmastlock;
   logic [31:0] m_hwdata;
   logic [31:0] m_hrdata;
   logic [15:0] stat_pass;
   logic [15:0] stat_fail;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // The arbiter forwards the monitor's response as the bus hready.
   assign s_hready = s_hready_resp;

   ahbl_excl_monitor #(
      .N_MASTERS(4),
      .W_ADDR(32),
      .W_DATA(32),
      .GRANULE_LOG2(3)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_hready(s_hready), .s_hready_resp(s_hready_resp), .s_hresp(s_hresp),
      .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_htrans(s_htrans), .s_hsize(s_hsize),
      .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock),
      .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hexcl(s_hexcl),
      .s_hmaster(s_hmaster), .s_hexokay(s_hexokay),
      .m_hready(m_hready), .m_hready_resp(m_hready_resp), .m_hresp(m_hresp),
      .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_htrans(m_htrans), .m_hsize(m_hsize),
      .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hmastlock(m_hmastlock),
      .m_hwdata(m_hwdata), .m_hrdata(m_hrdata),
      .stat_pass(stat_pass), .stat_fail(stat_fail)
   );

   // Memory slave: zero wait states, optional two-cycle error response.
   logic [31:0] mem [0:4095];
   logic        err_inject = 1'b0;
   logic        sl_valid = 1'b0;
   logic        sl_write = 1'b0;
   logic        sl_err = 1'b0;
   logic        sl_e2 = 1'b0;
   logic [31:0] sl_addr = '0;

   always_comb begin
      m_hready_resp = 1'b1;
      m_hresp       = 1'b0;
      m_hrdata      = '0;
      if (sl_valid && sl_err) begin
         m_hresp       = 1'b1;
         m_hready_resp = sl_e2;
      end else if (sl_valid && !sl_write) begin
         m_hrdata = mem[sl_addr[13:2]];
      end
   end

   always @(posedge clk) begin
      if (m_hready_resp) begin
         if (sl_valid && sl_write && !sl_err)
            mem[sl_addr[13:2]] <= m_hwdata;
         sl_e2 <= 1'b0;
      end else if (sl_valid && sl_err) begin
         sl_e2 <= 1'b1;
      end
      if (m_hready) begin
         sl_valid <= m_htrans[1];
         sl_addr  <= m_haddr;
         sl_write <= m_hwrite;
         sl_err   <= err_inject;
      end
   end

   typedef struct packed {
      logic        resp;
      logic        okay;
      logic        chk_rd;
      logic [31:0] rd;
      logic        one_cyc;
   } dexp_t;

   logic [1:0] q_addr [$];
   dexp_t      q_data [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the address-phase expectation on accept, the data-phase one on completion.
   initial begin : monitor
      logic   mon_dph;
      int     dcyc;
      dexp_t  d;
      logic [1:0] et;
      mon_dph = 1'b0;
      dcyc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_dph = 1'b0;
            dcyc = 0;
         end else begin
            if (mon_dph) begin
               dcyc++;
               if (s_hready_resp) begin
                  if (q_data.size() == 0) begin
                     check("data_queue_underflow", 32'd0, 32'd1);
                  end else begin
                     d = q_data.pop_front();
                     check("s_hresp", 32'(s_hresp), 32'(d.resp));
                     check("s_hexokay", 32'(s_hexokay), 32'(d.okay));
                     if (d.chk_rd) check("s_hrdata", s_hrdata, d.rd);
                     if (d.one_cyc) check("fail_dph_cycles", 32'(dcyc), 32'd1);
                  end
                  mon_dph = 1'b0;
                  dcyc = 0;
               end
            end
            if (s_hready && s_htrans[1]) begin
               if (q_addr.size() == 0) begin
                  check("addr_queue_underflow", 32'd0, 32'd1);
               end else begin
                  et = q_addr.pop_front();
                  check("m_htrans", 32'(m_htrans), 32'(et));
               end
               mon_dph = 1'b1;
               dcyc = 0;
            end
         end
      end
   end

   // One non-pipelined transfer; starts and ends 1 time unit after a rising edge.
   task automatic xfer(input logic [7:0] mst, input logic [31:0] addr, input logic wr,
                       input logic excl, input logic [31:0] wdata, input logic err,
                       input logic [1:0] e_mtrans, input logic e_resp, input logic e_okay,
                       input logic chk_rd, input logic [31:0] e_rd, input logic one_cyc);
      int cnt;
      dexp_t d;
      d.resp = e_resp; d.okay = e_okay; d.chk_rd = chk_rd; d.rd = e_rd; d.one_cyc = one_cyc;
      q_addr.push_back(e_mtrans);
      q_data.push_back(d);
      s_hmaster = mst; s_haddr = addr; s_hwrite = wr; s_hexcl = excl;
      s_htrans = 2'b10; err_inject = err;
      cnt = 0;
      @(negedge clk);
      while (!s_hready && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) check("addr_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      s_htrans = 2'b00; s_hexcl = 1'b0; s_hwdata = wdata; err_inject = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (!s_hready_resp && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) check("data_done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic chk_stats(input int p, input int f);
      int ep, ef;
      ep = p;
      ef = f;
`ifndef EXCL_MONITOR_STATS_EN
      ep = 0;
      ef = 0;
`endif
      check("stat_pass", 32'(stat_pass), 32'(ep));
      check("stat_fail", 32'(stat_fail), 32'(ef));
   endtask

   localparam logic [31:0] A1 = 32'h1111_0001, A2 = 32'h1111_0002, B1 = 32'h2222_0001;
   localparam logic [31:0] C1 = 32'h3333_0001, P1 = 32'hAAAA_0001, Q1 = 32'hBBBB_0002;
   localparam logic [31:0] R1 = 32'hCCCC_0003, S1 = 32'h5555_0004, T1 = 32'h6666_0005;
   localparam logic [31:0] U1 = 32'h7777_0007, X1 = 32'h8888_0008;

   initial begin : stim
      int cnt;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hready_resp", 32'(s_hready_resp), 32'd1);
      check("rst_hresp", 32'(s_hresp), 32'd0);
      check("rst_hexokay", 32'(s_hexokay), 32'd0);
      chk_stats(0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // args: mst addr wr excl wdata err | mtrans resp okay chk_rd rd one_cyc
      xfer(8'd3, 32'h1000, 1, 0, A1, 0, 2'b10, 0, 0, 0, '0, 0);
      xfer(8'd3, 32'h1004, 1, 0, A2, 0, 2'b10, 0, 0, 0, '0, 0);
      xfer(8'd3, 32'h2000, 1, 0, B1, 0, 2'b10, 0, 0, 0, '0, 0);
      xfer(8'd3, 32'h3000, 1, 0, C1, 0, 2'b10, 0, 0, 0, '0, 0);

      // Same-granule LR/SC pass
      xfer(8'd0, 32'h1000, 0, 1, '0, 0, 2'b10, 0, 1, 1, A1, 0);
      xfer(8'd0, 32'h1004, 1, 1, P1, 0, 2'b10, 0, 1, 0, '0, 0);
      xfer(8'd3, 32'h1004, 0, 0, '0, 0, 2'b10, 0, 0, 1, P1, 0);
      chk_stats(1, 0);

      // Intervening plain write kills the reservation
      xfer(8'd0, 32'h1000, 0, 1, '0, 0, 2'b10, 0, 1, 1, A1, 0);
      xfer(8'd1, 32'h1000, 1, 0, Q1, 0, 2'b10, 0, 0, 0, '0, 0);
      xfer(8'd0, 32'h1000, 1, 1, R1, 0, 2'b00, 0, 0, 0, '0, 1);
      xfer(8'd3, 32'h1000, 0, 0, '0, 0, 2'b10, 0, 0, 1, Q1, 0);
      chk_stats(1, 1);

      // Competing reservations: first store wins
      xfer(8'd0, 32'h2000, 0, 1, '0, 0, 2'b10, 0, 1, 1, B1, 0);
      xfer(8'd1, 32'h2000, 0, 1, '0, 0, 2'b10, 0, 1, 1, B1, 0);
      xfer(8'd1, 32'h2000, 1, 1, S1, 0, 2'b10, 0, 1, 0, '0, 0);
      xfer(8'd0, 32'h2000, 1, 1, T1, 0, 2'b00, 0, 0, 0, '0, 1);
      xfer(8'd3, 32'h2000, 0, 0, '0, 0, 2'b10, 0, 0, 1, S1, 0);
      chk_stats(2, 2);

      // No reservation; out-of-range master ID
      xfer(8'd2, 32'h3000, 1, 1, R1, 0, 2'b00, 0, 0, 0, '0, 1);
      xfer(8'd9, 32'h3000, 0, 1, '0, 0, 2'b10, 0, 0, 1, C1, 0);
      xfer(8'd1, 32'h3000, 1, 1, R1, 0, 2'b00, 0, 0, 0, '0, 1);
      xfer(8'd9, 32'h3000, 1, 1, R1, 0, 2'b00, 0, 0, 0, '0, 1);
      chk_stats(2, 5);

      // Slave error on exclusive read clears the reservation
      xfer(8'd2, 32'h3000, 0, 1, '0, 1, 2'b10, 1, 0, 0, '0, 0);
      xfer(8'd2, 32'h3000, 1, 1, T1, 0, 2'b00, 0, 0, 0, '0, 1);
      chk_stats(2, 6);

      // Plain read and other-granule write leave the reservation intact
      xfer(8'd2, 32'h3000, 0, 1, '0, 0, 2'b10, 0, 1, 1, C1, 0);
      xfer(8'd3, 32'h3000, 0, 0, '0, 0, 2'b10, 0, 0, 1, C1, 0);
      xfer(8'd3, 32'h3008, 1, 0, X1, 0, 2'b10, 0, 0, 0, '0, 0);
      xfer(8'd2, 32'h3000, 1, 1, U1, 0, 2'b10, 0, 1, 0, '0, 0);
      xfer(8'd3, 32'h3000, 0, 0, '0, 0, 2'b10, 0, 0, 1, U1, 0);
      chk_stats(3, 6);

      // Reset between LR and SC
      xfer(8'd0, 32'h1000, 0, 1, '0, 0, 2'b10, 0, 1, 1, Q1, 0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_stats(0, 0);
      @(posedge clk); #1;
      xfer(8'd0, 32'h1000, 1, 1, R1, 0, 2'b00, 0, 0, 0, '0, 1);
      xfer(8'd3, 32'h1000, 0, 0, '0, 0, 2'b10, 0, 0, 1, Q1, 0);
      chk_stats(0, 1);

      cnt = 0;
      while ((q_addr.size() != 0 || q_data.size() != 0) && cnt < 20) begin
         @(posedge clk);
         cnt++;
      end
      check("scoreboard_drained", 32'(q_addr.size() + q_data.size()), 32'd0);
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
